// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler and its clients.
// Op codes, FSM states and common widths.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOR = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_t;

endpackage

// File: rtl/alu_req_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid requester
// at or after rr_ptr, wrapping modulo N_REQ.
module rr_pick
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  grant,
  output logic             any_valid
);

  int              idx;
  logic [ID_W-1:0] ix;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    ix        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      ix = ID_W'(idx);
      if (!any_valid && req_valid[ix]) begin
        any_valid = 1'b1;
        grant     = ix;
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between N_REQ requesters.
// Round-robin grant, registered operands, held response.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [2:0]             alu_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] id_r;
  logic            any_valid;

  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .any_valid(any_valid)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept strobe is only offered from IDLE, never while in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == ST_IDLE && any_valid)
      req_ready[grant] = 1'b1;
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // alu_sel/alu_a/alu_b double as the latched op/operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      id_r     <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_valid) begin
            alu_sel <= sel_op;
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            id_r    <= grant;
            rr_ptr  <= (grant == ID_W'(N_REQ-1)) ? '0
                                                 : grant + 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data <= alu_result;
          rsp_id   <= id_r;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
Round-robin scheduler that shares one combinational 8-operation ALU between N_REQ requesters.
- Accepts per-requester operation requests with a valid/ready handshake.
- Drives the ALU's 3-bit operation select and operands from registers.
- Captures the result and returns it with the winner's ID on a valid/ready response channel.
- Sits between the ALU mux tree and the client blocks (register-file sequencer, test driver).

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits
ID_W, 2, requester ID width; must equal ceil(log2(N_REQ))

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_op  input  3*N_REQ  per-requester op select; slice i = bits [3i+2:3i]
req_a  input  WIDTH*N_REQ  per-requester operand A, slice i
req_b  input  WIDTH*N_REQ  per-requester operand B, slice i
req_ready  output  N_REQ  one-hot accept strobe
alu_sel  output  3  ALU op select; bit0=s0, bit1=s1, bit2=s2
alu_a  output  WIDTH  ALU operand A
alu_b  output  WIDTH  ALU operand B
alu_result  input  WIDTH  combinational ALU result for alu_sel/alu_a/alu_b
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  requester index of the response
rsp_data  output  WIDTH  captured ALU result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk edge).
  - While rst_n=0: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_sel=0, alu_a=0, alu_b=0, busy=0.
  - Reset mid-operation discards the in-flight op. No response is produced and no req_ready is re-issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req_valid==0: stay in IDLE.
  - Otherwise grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ... (mod N_REQ).
  - req_ready is combinational in IDLE: req_ready[g]=1, all other bits 0. The transfer occurs in this cycle.
  - On the edge: latch op_r=req_op slice g, a_r, b_r, id_r=g; set rr_ptr=(g+1) mod N_REQ; go to EXEC.
- EXEC:
  - alu_sel=op_r, alu_a=a_r, alu_b=b_r; these are held registered values, stable the whole cycle.
  - On the edge: rsp_data<=alu_result, rsp_id<=id_r; go to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id are stable until accepted.
  - If rsp_ready=1: transfer occurs; next state IDLE, and rsp_valid drops next cycle.
  - If rsp_ready=0: stay in RESP indefinitely.
- req_ready is 0 in EXEC and RESP. A request is never accepted while another is outstanding.
- Requesters may change or drop req_valid while not granted. No ordering or fairness is guaranteed for dropped requests.
- alu_sel/alu_a/alu_b hold their last values outside EXEC; they are not zeroed.
- Latency and throughput:
  - Accept to rsp_valid = 2 cycles.
  - With rsp_ready held at 1: one op per 3 cycles.
- Arithmetic: no arithmetic is performed here. rsp_data is a WIDTH-bit copy of alu_result; overflow semantics belong to the ALU.
- rr_ptr wraps from N_REQ-1 to 0. A requester that holds req_valid high gets at most one grant per N_REQ grants while others are also requesting.
- Simultaneous events: rsp_ready in the same cycle as new req_valid does not grant that cycle; the grant happens in the following IDLE cycle.

Decomposition:
- Shared package alu_pkg:
  - OP_W=3.
  - State encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - Op code names for the 8 ALU ops (shared with the ALU and test benches).
- Sub-module rr_pick:
  - Purely combinational round-robin priority picker.
  - Inputs: req_valid, rr_ptr. Outputs: grant index, any_valid.
  - Instantiated once in the scheduler.

Test Plan:
1. Reset/idle:
   - Stimulus: rst_n=0 for 2 cycles, req_valid=0 afterwards.
   - Required: all outputs 0 and busy=0 throughout; state stays IDLE.
2. Single request:
   - Stimulus: req_valid=4'b0100, op=3'b101, a=8'h3C, b=8'h0F; ALU model returns a^b; rsp_ready=1.
   - Required: req_ready=4'b0100 in the request cycle; alu_sel=3'b101, alu_a=8'h3C, alu_b=8'h0F in the next cycle; one cycle later rsp_valid=1, rsp_id=2, rsp_data=8'h33.
3. Round-robin fairness:
   - Stimulus: req_valid=4'b1111 held for 12 ops.
   - Required: grant order 0,1,2,3,0,1,2,3,0,1,2,3; each rsp_id matches.
4. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles during RESP, then 1.
   - Required: rsp_valid, rsp_data, rsp_id stable for all 5 cycles; req_ready=0 throughout; next grant occurs in the first IDLE cycle.
5. Wrap and skip:
   - Stimulus: rr_ptr=3 (after a grant to 2), req_valid=4'b0010.
   - Required: grant index 1; rr_ptr becomes 2.
6. Reset mid-op:
   - Stimulus: rst_n=0 during EXEC, then a new request from requester 0.
   - Required: no response for the aborted op; the next response has rsp_id=0, with rr_ptr having restarted at 0.
